// File: rtl/mem8x8_pkg.sv
// mem8x8_pkg: shared types and constants for the 8x8 memory sequencer
package mem8x8_pkg;
  localparam int MEM_AW = 3;
  localparam int MEM_DW = 8;
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ = 1'b0;
  typedef enum logic [2:0] {IDLE, SETUP, WRITE, RECOVER, VERIFY, RESP} state_t;
endpackage

// File: rtl/mem8x8_ctrl.sv
// mem8x8_ctrl: sequences single read/write requests onto the 8x8 array with settle/write-pulse timing
// Optional write read-back check enabled by defining MEM8X8_CTRL_VERIFY_EN.
module mem8x8_ctrl
  import mem8x8_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int WRITE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [MEM_AW-1:0] req_addr,
  input  logic [MEM_DW-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [MEM_DW-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [MEM_AW-1:0] mem_address,
  output logic [MEM_DW-1:0] mem_data_in,
  output logic              mem_select,
  output logic              mem_rw,
  input  logic [MEM_DW-1:0] mem_data_out
);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] WRITE_LD = 4'(WRITE_CYCLES - 1);
  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic is_write, done, accept;
  assign done = cnt == 4'd0;
  assign accept = state == IDLE && req_valid;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign mem_select = state != IDLE && state != RESP;
  assign mem_rw = state == WRITE ? RW_WRITE : RW_READ;
  always_comb begin
    state_nxt = state;
    cnt_nxt = done ? 4'd0 : cnt - 4'd1;
    case (state)
      IDLE: begin
        state_nxt = req_valid ? SETUP : IDLE;
        cnt_nxt = SETTLE_LD;
      end
      SETUP: if (done) begin
        state_nxt = is_write ? WRITE : RESP;
        cnt_nxt = WRITE_LD;
      end
      WRITE: if (done) begin
`ifdef MEM8X8_CTRL_VERIFY_EN
        state_nxt = VERIFY;
`else
        state_nxt = RECOVER;
`endif
        cnt_nxt = SETTLE_LD;
      end
      RECOVER: state_nxt = RESP;
`ifdef MEM8X8_CTRL_VERIFY_EN
      VERIFY: state_nxt = done ? RESP : VERIFY;
`endif
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      is_write <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      if (accept) begin
        is_write <= req_write;
        mem_address <= req_addr;
        mem_data_in <= req_wdata;
      end
      if (state == SETUP && done && !is_write) rsp_rdata <= mem_data_out;
    end
`ifdef MEM8X8_CTRL_VERIFY_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) rsp_err <= 1'b0;
    else if (accept) rsp_err <= 1'b0;
    else if (state == VERIFY && done) rsp_err <= mem_data_out != mem_data_in;
`else
  assign rsp_err = 1'b0;
`endif
endmodule

// File: doc/mem8x8_ctrl.md
# mem8x8_ctrl

Request sequencer that sits directly upstream of the 8x8 memory array (`memory8x8`). It accepts single read/write requests over a valid/ready handshake and drives the array's `address`, `data_in`, `select` and `rw` inputs with guaranteed decoder-settle and write-pulse timing. It returns read data or write completion as a one-cycle response pulse. The array is instantiated by the parent; this block only owns the access timing.

## Interface
- `SETTLE_CYCLES`, 2, cycles the address/select are held with `rw=0` before sampling or writing; legal range 1..15
- `WRITE_CYCLES`, 1, cycles `mem_rw` is held high for a write; legal range 1..15
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset; one clock, asynchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  block idle and accepting; reset 1
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  3  word address
- `req_wdata`  in  8  write data
- `rsp_valid`  out  1  one-cycle completion pulse; reset 0
- `rsp_rdata`  out  8  read data, held until next read completes; reset 8'h00
- `rsp_err`  out  1  write-verify mismatch, valid with `rsp_valid`; reset 0
- `mem_address`  out  3  to array `address`; reset 3'b000
- `mem_data_in`  out  8  to array `data_in`; reset 8'h00
- `mem_select`  out  1  to array `select`; reset 0
- `mem_rw`  out  1  to array `rw`; 1 = write, 0 = read; reset 0
- `mem_data_out`  in  8  from array `data_out`

## Operation
- States: IDLE, SETUP, WRITE, RECOVER, VERIFY, RESP. Reset → IDLE.
- IDLE: `req_ready=1`, `mem_select=0`, `mem_rw=0`. Handshake = `req_valid & req_ready` at a rising edge; on it register `req_addr`→`mem_address`, `req_wdata`→`mem_data_in`, latch `req_write`, go SETUP.
- SETUP: `mem_select=1`, `mem_rw=0`, lasts exactly SETTLE_CYCLES cycles (down-counter loaded on entry). Exit: read → RESP, capturing `mem_data_out` into `rsp_rdata` on the exit edge; write → WRITE.
- WRITE: `mem_select=1`, `mem_rw=1` for WRITE_CYCLES cycles, then RECOVER (or VERIFY, see Configuration).
- RECOVER: `mem_select=1`, `mem_rw=0`, one cycle, then RESP.
- RESP: `rsp_valid=1` for exactly one cycle, `mem_select=0`, `req_ready=0`; then IDLE. No response backpressure.
- `mem_address`/`mem_data_in` are stable from accept until the next accept; they never change while `mem_select=1`.
- `req_ready` is 0 in every state except IDLE; requests presented while busy are ignored until IDLE.
- Write responses leave `rsp_rdata` unchanged; `rsp_err=0` on reads.
- Reset mid-operation: all outputs go to reset values immediately (asynchronous); an interrupted write leaves that array word undefined.

## Timing
- Accept edge E0. Read: `rsp_valid` high in the cycle after edge E0+SETTLE_CYCLES (defaults: 3rd cycle after accept), `rsp_rdata` valid same cycle.
- Write: `mem_rw` high for edges E0+SETTLE_CYCLES .. E0+SETTLE_CYCLES+WRITE_CYCLES; `rsp_valid` after edge E0+SETTLE_CYCLES+WRITE_CYCLES+1.
- Back-to-back: next accept possible at the edge ending the IDLE cycle following RESP; minimum request period = latency + 2 cycles.
- `mem_rw` never rises in the same cycle `mem_select` rises or `mem_address` changes.

## Configuration
- `MEM8X8_CTRL_VERIFY_EN` defined: after WRITE go to VERIFY (`mem_select=1`, `mem_rw=0`, SETTLE_CYCLES cycles), compare `mem_data_out` to `mem_data_in` on the exit edge, `rsp_err` = mismatch, then RESP. Write latency becomes E0+2·SETTLE_CYCLES+WRITE_CYCLES.
- Undefined: VERIFY state and comparator absent, RECOVER used, `rsp_err` tied 0.

## Structure
- Shared package `mem8x8_pkg`: state enum, `MEM_AW=3`, `MEM_DW=8`, rw encoding constants (`RW_WRITE=1`, `RW_READ=0`).
- Single module, no sub-module; one 4-bit down-counter shared by SETUP/WRITE/VERIFY.

## Test plan
- Reset: assert `rst` mid-cycle → `req_ready=1`, `mem_select=0`, `mem_rw=0`, `rsp_rdata=00` without waiting for an edge.
- Read of address 000 after reset with array cleared → `rsp_rdata=00000000`, `rsp_valid` exactly SETTLE_CYCLES edges after accept.
- Write 10101010 to 000, then read 000 → `rsp_rdata=10101010`; `mem_rw` high exactly WRITE_CYCLES cycles, address/data stable throughout.
- Write 8'h5A to 7, 8'hC3 to 3, read 7 and 3 back-to-back → 5A, C3; `req_ready` low while busy, `req_valid` held during busy is not double-accepted.
- Assert `rst` during WRITE → `mem_rw` drops immediately, no `rsp_valid`, next request accepted normally.
- With `MEM8X8_CTRL_VERIFY_EN`, force array bit 0 stuck at 0, write 8'hFF → `rsp_err=1`; write 8'hFE → `rsp_err=0`.
